// File: rtl/text_term_pkg.sv
// Shared constants, state encoding and byte classification for the text terminal.
package text_term_pkg;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        CLRSCR  = 2'd2,
        CLRLINE = 2'd3
    } term_state_t;

    // Bytes that are drawn as glyphs: 0x20..0x7E plus the whole upper half.
    function automatic logic is_printable(input logic [7:0] b);
        return ((b >= 8'h20) && (b <= 8'h7E)) || b[7];
    endfunction

endpackage

// File: rtl/text_cursor_counter.sv
// Row/column cursor with wrap-around stepping and linear cell index outputs.
// Wrap is detected by comparing against the last row/column, never by modulo.
module text_cursor_counter
    import text_term_pkg::*;
#(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              home,
    input  logic              dec,
    input  logic              inc,
    input  logic              col_zero,
    input  logic              next_row,
    output logic [ADDR_W-1:0] index,
    output logic [ADDR_W-1:0] prev_index,
    output logic [ADDR_W-1:0] next_row_base,
    output logic              inc_wraps_row
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          last_col;
    logic          last_row;
    logic [RW-1:0] row_inc;
    logic [RW-1:0] row_dec;

    assign last_col = (col == CW'(COLS - 1));
    assign last_row = (row == RW'(ROWS - 1));
    assign row_inc  = last_row ? '0 : row + RW'(1);
    assign row_dec  = (row == '0) ? RW'(ROWS - 1) : row - RW'(1);

    assign index         = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
    // Cell one step back; at column 0 that is the last column of the previous row.
    assign prev_index    = (col == '0) ? ADDR_W'(row_dec) * ADDR_W'(COLS) + ADDR_W'(COLS - 1)
                                       : index - ADDR_W'(1);
    assign next_row_base = ADDR_W'(row_inc) * ADDR_W'(COLS);
    assign inc_wraps_row = last_col;

    // Cursor update; controls are mutually exclusive in practice, home dominates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (home) begin
            row <= '0;
            col <= '0;
        end else if (dec) begin
            if (col == '0) begin
                col <= CW'(COLS - 1);
                row <= row_dec;
            end else begin
                col <= col - CW'(1);
            end
        end else if (inc) begin
            if (last_col) begin
                col <= '0;
                row <= row_inc;
            end else begin
                col <= col + CW'(1);
            end
        end else if (col_zero) begin
            col <= '0;
        end else if (next_row) begin
            row <= row_inc;
        end
    end

endmodule

// File: rtl/text_terminal_writer.sv
// Byte-stream terminal engine: turns received characters into text buffer writes,
// tracks the cursor and interprets BS, CR, LF and FF.
// Optional build macro TERM_CLEAR_LINE_EN: every entry onto a new row blanks that row.
//
// Byte handshake: a byte transfers in any cycle where i_Byte_Valid and o_Byte_Ready
// are both high; o_Byte_Ready is high only in IDLE, and i_Byte must be held with
// i_Byte_Valid until that cycle. Move pulses are only honoured in IDLE when no byte
// transfers in the same cycle.
module text_terminal_writer
    import text_term_pkg::*;
#(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [7:0]        i_Byte,
    input  logic              i_Byte_Valid,
    output logic              o_Byte_Ready,
    input  logic              i_Cmd_Home,
    input  logic              i_Cmd_Left,
    input  logic              i_Cmd_Right,
    input  logic              i_Cmd_Down,
    output logic              o_Wr_En,
    output logic [ADDR_W-1:0] o_Wr_Addr,
    output logic [7:0]        o_Wr_Data,
    output logic [ADDR_W-1:0] o_Cursor,
    output logic              o_Busy
);

`ifdef TERM_CLEAR_LINE_EN
    localparam bit CLR_LINE_EN = 1'b1;
`else
    localparam bit CLR_LINE_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(COLS - 1);

    term_state_t       state;
    logic [7:0]        byte_q;
    logic [ADDR_W-1:0] clr_cnt;

    logic              accept;
    logic              move_ok;
    logic              in_exec;
    logic              clr_done;
    logic              down_take;
    logic              exec_new_row;
    logic              c_home;
    logic              c_dec;
    logic              c_inc;
    logic              c_col_zero;
    logic              c_next_row;
    logic [ADDR_W-1:0] prev_index;
    logic [ADDR_W-1:0] next_row_base;
    logic              inc_wraps_row;

    assign o_Busy = (state != IDLE);

    // Decode this cycle's cursor action from the state, latched byte and move pulses.
    always_comb begin
        accept       = (state == IDLE) && i_Byte_Valid;
        move_ok      = (state == IDLE) && !i_Byte_Valid;
        in_exec      = (state == EXEC);
        clr_done     = (state == CLRSCR) && (o_Wr_Addr == LAST_ADDR);
        down_take    = move_ok && i_Cmd_Down && !i_Cmd_Home && !i_Cmd_Left && !i_Cmd_Right;
        exec_new_row = (is_printable(byte_q) && inc_wraps_row) || (byte_q == CH_LF);

        c_home     = (move_ok && i_Cmd_Home) || clr_done;
        c_dec      = (move_ok && !i_Cmd_Home && i_Cmd_Left)
                   || (in_exec && (byte_q == CH_BS));
        c_inc      = (move_ok && !i_Cmd_Home && !i_Cmd_Left && i_Cmd_Right)
                   || (in_exec && is_printable(byte_q));
        c_col_zero = in_exec && (byte_q == CH_CR);
        c_next_row = down_take || (in_exec && (byte_q == CH_LF));
    end

    text_cursor_counter #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_cursor (
        .clk           (i_Clk),
        .rst_n         (i_Rst_L),
        .home          (c_home),
        .dec           (c_dec),
        .inc           (c_inc),
        .col_zero      (c_col_zero),
        .next_row      (c_next_row),
        .index         (o_Cursor),
        .prev_index    (prev_index),
        .next_row_base (next_row_base),
        .inc_wraps_row (inc_wraps_row)
    );

    // Control FSM; the write port is registered so a byte's write lands the cycle after acceptance.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state        <= IDLE;
            byte_q       <= '0;
            clr_cnt      <= '0;
            o_Byte_Ready <= 1'b1;
            o_Wr_En      <= 1'b0;
            o_Wr_Addr    <= '0;
            o_Wr_Data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        byte_q       <= i_Byte;
                        o_Byte_Ready <= 1'b0;
                        if (i_Byte == CH_FF) begin
                            state     <= CLRSCR;
                            o_Wr_En   <= 1'b1;
                            o_Wr_Addr <= '0;
                            o_Wr_Data <= CH_SPACE;
                        end else begin
                            state <= EXEC;
                            if (is_printable(i_Byte)) begin
                                o_Wr_En   <= 1'b1;
                                o_Wr_Addr <= o_Cursor;
                                o_Wr_Data <= i_Byte;
                            end else if (i_Byte == CH_BS) begin
                                o_Wr_En   <= 1'b1;
                                o_Wr_Addr <= prev_index;
                                o_Wr_Data <= CH_SPACE;
                            end
                        end
                    end else if (CLR_LINE_EN && down_take) begin
                        state        <= CLRLINE;
                        o_Byte_Ready <= 1'b0;
                        o_Wr_En      <= 1'b1;
                        o_Wr_Addr    <= next_row_base;
                        o_Wr_Data    <= CH_SPACE;
                        clr_cnt      <= '0;
                    end
                end
                EXEC: begin
                    if (CLR_LINE_EN && exec_new_row) begin
                        state     <= CLRLINE;
                        o_Wr_En   <= 1'b1;
                        o_Wr_Addr <= next_row_base;
                        o_Wr_Data <= CH_SPACE;
                        clr_cnt   <= '0;
                    end else begin
                        state        <= IDLE;
                        o_Wr_En      <= 1'b0;
                        o_Byte_Ready <= 1'b1;
                    end
                end
                CLRSCR: begin
                    if (clr_done) begin
                        state        <= IDLE;
                        o_Wr_En      <= 1'b0;
                        o_Byte_Ready <= 1'b1;
                    end else begin
                        o_Wr_Addr <= o_Wr_Addr + ADDR_W'(1);
                    end
                end
                CLRLINE: begin
                    if (clr_cnt == LAST_COL) begin
                        state        <= IDLE;
                        o_Wr_En      <= 1'b0;
                        o_Byte_Ready <= 1'b1;
                    end else begin
                        o_Wr_Addr <= o_Wr_Addr + ADDR_W'(1);
                        clr_cnt   <= clr_cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    state        <= IDLE;
                    o_Wr_En      <= 1'b0;
                    o_Byte_Ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_terminal_writer.sv
// Self-checking bench for text_terminal_writer: cursor model plus write scoreboard.
module tb_text_terminal_writer;

    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int ADDR_W = 12;
    localparam int CELLS  = COLS * ROWS;
`ifdef TERM_CLEAR_LINE_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [7:0]        in_byte;
    logic              byte_valid;
    logic              byte_ready;
    logic              cmd_home, cmd_left, cmd_right, cmd_down;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [ADDR_W-1:0] cursor;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    logic [ADDR_W+8-1:0] exp_q[$];

    int mrow = 0;
    int mcol = 0;

    text_terminal_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_n),
        .i_Byte       (in_byte),
        .i_Byte_Valid (byte_valid),
        .o_Byte_Ready (byte_ready),
        .i_Cmd_Home   (cmd_home),
        .i_Cmd_Left   (cmd_left),
        .i_Cmd_Right  (cmd_right),
        .i_Cmd_Down   (cmd_down),
        .o_Wr_En      (wr_en),
        .o_Wr_Addr    (wr_addr),
        .o_Wr_Data    (wr_data),
        .o_Cursor     (cursor),
        .o_Busy       (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic int midx();
        return mrow * COLS + mcol;
    endfunction

    function automatic int wrap_row(input int r);
        return (r == ROWS - 1) ? 0 : r + 1;
    endfunction

    task automatic push_wr(input int addr, input logic [7:0] data);
        exp_q.push_back({ADDR_W'(addr), data});
    endtask

    task automatic push_line_clear();
        for (int i = 0; i < COLS; i++) push_wr(mrow * COLS + i, 8'h20);
    endtask

    // Model step forward; returns 1 when a new row is entered.
    function automatic bit model_adv();
        if (mcol == COLS - 1) begin
            mcol = 0;
            mrow = wrap_row(mrow);
            return 1'b1;
        end
        mcol = mcol + 1;
        return 1'b0;
    endfunction

    function automatic void model_back();
        if (mcol == 0) begin
            mcol = COLS - 1;
            mrow = (mrow == 0) ? ROWS - 1 : mrow - 1;
        end else begin
            mcol = mcol - 1;
        end
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            check("wr_outside_idle", 32'(busy), 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_wr", {12'd0, wr_addr, wr_data}, 32'hFFFFFFFF);
            end else begin
                check("wr", 32'({wr_addr, wr_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_ready(input string tag, input int exp_lat);
        int cyc;
        cyc = 1;
        while (!byte_ready && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check(tag, 32'(cyc), 32'(exp_lat));
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_right);
        bit exp_wr;
        bit new_row;
        int lat;
        exp_wr  = 1'b0;
        new_row = 1'b0;
        lat     = 2;
        if (b == 8'h0C) begin
            for (int i = 0; i < CELLS; i++) push_wr(i, 8'h20);
            mrow = 0; mcol = 0;
            exp_wr = 1'b1;
            lat = CELLS + 1;
        end else if ((b >= 8'h20 && b <= 8'h7E) || b >= 8'h80) begin
            push_wr(midx(), b);
            new_row = model_adv();
            exp_wr = 1'b1;
        end else if (b == 8'h08) begin
            model_back();
            push_wr(midx(), 8'h20);
            exp_wr = 1'b1;
        end else if (b == 8'h0D) begin
            mcol = 0;
        end else if (b == 8'h0A) begin
            mrow = wrap_row(mrow);
            new_row = 1'b1;
        end
        if (CLR && new_row) begin
            push_line_clear();
            lat = lat + COLS;
        end
        @(negedge clk);
        check("ready_before_byte", 32'(byte_ready), 32'd1);
        in_byte    = b;
        byte_valid = 1'b1;
        cmd_right  = with_right;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        cmd_right  = 1'b0;
        check("wr_en_n1", 32'(wr_en), 32'(exp_wr));
        wait_ready("byte_latency", lat);
        check("cursor_after_byte", 32'(cursor), 32'(midx()));
    endtask

    task automatic move(input bit h, input bit l, input bit r, input bit d);
        bit new_row;
        new_row = 1'b0;
        if (h) begin
            mrow = 0; mcol = 0;
        end else if (l) begin
            model_back();
        end else if (r) begin
            void'(model_adv());
        end else if (d) begin
            mrow = wrap_row(mrow);
            new_row = 1'b1;
        end
        if (CLR && new_row) push_line_clear();
        @(negedge clk);
        cmd_home = h; cmd_left = l; cmd_right = r; cmd_down = d;
        @(posedge clk); #1;
        cmd_home = 1'b0; cmd_left = 1'b0; cmd_right = 1'b0; cmd_down = 1'b0;
        check("cursor_after_move", 32'(cursor), 32'(midx()));
        wait_ready("move_latency", (CLR && new_row) ? COLS + 1 : 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; in_byte = '0; byte_valid = 1'b0;
        cmd_home = 1'b0; cmd_left = 1'b0; cmd_right = 1'b0; cmd_down = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(byte_ready), 32'd1);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_cursor", 32'(cursor), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Printable at the origin
        send_byte(8'h41, 1'b0);
        check("cursor_a", 32'(cursor), 32'd1);

        // Last cell then wrap to the origin
        move(1, 0, 0, 0);
        move(0, 1, 0, 0);
        check("cursor_last", 32'(cursor), 32'(CELLS - 1));
        send_byte(8'h5A, 1'b0);
        check("cursor_wrap_z", 32'(cursor), 32'd0);

        // Backspace from the origin
        send_byte(8'h08, 1'b0);
        check("cursor_bs", 32'(cursor), 32'(CELLS - 1));

        // Cursor to 165, then CR and LF
        move(1, 0, 0, 0);
        move(0, 0, 0, 1);
        move(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) move(0, 0, 1, 0);
        check("cursor_165", 32'(cursor), 32'd165);
        send_byte(8'h0D, 1'b0);
        check("cursor_cr", 32'(cursor), 32'd160);
        send_byte(8'h0A, 1'b0);
        check("cursor_lf", 32'(cursor), 32'd240);

        // Move priority and wrap
        move(1, 1, 1, 1);
        check("prio_home", 32'(cursor), 32'd0);
        move(0, 1, 1, 0);
        check("prio_left", 32'(cursor), 32'(CELLS - 1));
        move(0, 0, 1, 1);
        check("right_wrap", 32'(cursor), 32'd0);

        // Move pulse coinciding with a byte handshake is dropped
        send_byte(8'h42, 1'b1);
        check("move_dropped", 32'(cursor), 32'd1);

        // Random mix of printable, control and ignored codes
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            case ($urandom_range(0, 5))
                0, 1: b = 8'($urandom_range(32, 126));
                2:    b = 8'($urandom_range(128, 255));
                3:    b = 8'($urandom_range(0, 7));
                4:    b = 8'h7F;
                default: begin
                    case ($urandom_range(0, 2))
                        0: b = 8'h08;
                        1: b = 8'h0D;
                        default: b = 8'h0A;
                    endcase
                end
            endcase
            send_byte(b, 1'b0);
        end

        // Full screen clear
        send_byte(8'h0C, 1'b0);
        check("cursor_ff", 32'(cursor), 32'd0);
        check("q_empty_after_ff", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a clear
        for (int i = 0; i < CELLS; i++) push_wr(i, 8'h20);
        @(negedge clk);
        in_byte = 8'h0C; byte_valid = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midclr_wr_en", 32'(wr_en), 32'd0);
        check("midclr_wr_addr", 32'(wr_addr), 32'd0);
        check("midclr_ready", 32'(byte_ready), 32'd1);
        check("midclr_busy", 32'(busy), 32'd0);
        check("midclr_cursor", 32'(cursor), 32'd0);
        exp_q.delete();
        mrow = 0; mcol = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        send_byte(8'h43, 1'b0);
        check("cursor_post_rst", 32'(cursor), 32'd1);

        repeat (5) @(posedge clk);
        check("q_empty_end", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
